// File: rtl/core_v_mini_mcu_pkg.sv
// MCU-wide constants shared by top-level instances.
package core_v_mini_mcu_pkg;

    localparam int unsigned REG_TO_OBI_TIMEOUT = 255;

endpackage

// File: rtl/obi_pkg.sv
// OBI initiator request and target response types used on the system bus.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/reg_pkg.sv
// Register-bus request/response types shared by reg-bus masters and slaves.
package reg_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;

endpackage

// File: rtl/reg_to_obi_bridge.sv
// Turns one reg-bus request at a time into a single OBI transaction, with a
// bounded wait on the response phase so a hung slave cannot stall the master.
module reg_to_obi_bridge
    import reg_pkg::*;
    import obi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = core_v_mini_mcu_pkg::REG_TO_OBI_TIMEOUT
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  reg_req_t  reg_req_i,
    output reg_rsp_t  reg_rsp_o,
    output obi_req_t  obi_req_o,
    input  obi_resp_t obi_resp_i
);

    // state   | meaning
    // IDLE    | waiting for reg valid, captures request
    // REQ     | OBI req held until gnt
    // WAIT_R  | waiting for rvalid, timeout counter running
    // RSP     | one-cycle ready to the reg master
    // DRAIN   | swallowing the stale rvalid after a timeout
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_RSP,
        S_DRAIN
    } state_e;

    localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_e           r_state;
    state_e           w_state_nxt;

    logic             r_req;
    logic             r_we;
    logic [3:0]       r_be;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_ready;
    logic [31:0]      r_rdata;
    logic             r_error;
    logic [CNT_W-1:0] r_cnt;
    logic             r_late;

    logic             w_timeout;
    logic             w_capture;
    logic             w_req_nxt;
    logic             w_rsp_load;
    logic [31:0]      w_rdata_nxt;
    logic             w_error_nxt;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_late_set;
    logic             w_late_clr;

    assign w_timeout = (r_cnt == CNT_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (reg_req_i.valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (obi_resp_i.gnt) begin
                    w_state_nxt = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (obi_resp_i.rvalid || w_timeout) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                w_state_nxt = r_late ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (obi_resp_i.rvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_capture   = 1'b0;
        w_rsp_load  = 1'b0;
        w_rdata_nxt = '0;
        w_error_nxt = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_late_set  = 1'b0;
        w_late_clr  = 1'b0;
        case (r_state)
            S_IDLE:  w_capture = reg_req_i.valid;
            S_REQ:   w_cnt_clr = obi_resp_i.gnt;
            S_WAIT_R: begin
                w_cnt_inc = (r_cnt != CNT_LIMIT);
                // rvalid takes priority over a timeout landing in the same cycle
                if (obi_resp_i.rvalid) begin
                    w_rsp_load  = 1'b1;
                    w_rdata_nxt = r_we ? 32'h0 : obi_resp_i.rdata;
                end else if (w_timeout) begin
                    w_rsp_load  = 1'b1;
                    w_error_nxt = 1'b1;
                    w_late_set  = 1'b1;
                end
            end
            S_DRAIN: w_late_clr = obi_resp_i.rvalid;
            default: ;
        endcase
        w_req_nxt = (w_state_nxt == S_REQ);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_error <= 1'b0;
            r_cnt   <= '0;
            r_late  <= 1'b0;
        end else begin
            r_req   <= w_req_nxt;
            r_ready <= w_rsp_load;
            if (w_capture) begin
                r_addr  <= reg_req_i.addr & 32'hFFFF_FFFC;
                r_we    <= reg_req_i.write;
                r_wdata <= reg_req_i.wdata;
                r_be    <= reg_req_i.write ? reg_req_i.wstrb : 4'hF;
            end
            if (w_rsp_load) begin
                r_rdata <= w_rdata_nxt;
                r_error <= w_error_nxt;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_late_set) begin
                r_late <= 1'b1;
            end else if (w_late_clr) begin
                r_late <= 1'b0;
            end
        end
    end

    assign obi_req_o.req   = r_req;
    assign obi_req_o.we    = r_we;
    assign obi_req_o.be    = r_be;
    assign obi_req_o.addr  = r_addr;
    assign obi_req_o.wdata = r_wdata;

    assign reg_rsp_o.ready = r_ready;
    assign reg_rsp_o.rdata = r_rdata;
    assign reg_rsp_o.error = r_error;

endmodule

// File: tb/tb_reg_to_obi_bridge.sv
// Scoreboard bench for reg_to_obi_bridge: directed timing cases plus a random
// back-to-back run against a small word memory model.
module tb_reg_to_obi_bridge;
    import reg_pkg::*;
    import obi_pkg::*;

    localparam int unsigned TMO = 4;

    logic      clk;
    logic      rst;
    reg_req_t  reg_req;
    reg_rsp_t  reg_rsp;
    obi_req_t  obi_req;
    obi_resp_t obi_resp;

    int          n_vec    = 0;
    int          n_err    = 0;
    int          n_ready  = 0;
    int          n_pushed = 0;
    logic [32:0] exp_q[$];
    logic [31:0] mem[4];

    reg_to_obi_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .reg_req_i (reg_req),
        .reg_rsp_o (reg_rsp),
        .obi_req_o (obi_req),
        .obi_resp_i(obi_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response side of the scoreboard: every ready pulse pops one expectation.
    always @(negedge clk) begin : mon
        logic [32:0] e;
        if (!rst && reg_rsp.ready) begin
            n_ready++;
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'(reg_rsp.ready), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", 64'(reg_rsp.rdata), 64'(e[32:1]));
                check("rsp_error", 64'(reg_rsp.error), 64'(e[0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic push, input logic [32:0] exp);
        reg_req.valid = 1'b1;
        reg_req.write = wr;
        reg_req.addr  = addr;
        reg_req.wdata = wdata;
        reg_req.wstrb = strb;
        if (push) begin
            exp_q.push_back(exp);
            n_pushed++;
        end
    endtask

    // Entered on the negedge of the first cycle req is expected high.
    task automatic txn_body(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int gd, input int rd,
                            input logic [31:0] bus_rd, input string tag);
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_be   = wr ? strb : 4'hF;
        for (int i = 0; i <= gd; i++) begin
            check({tag, ".req"},   64'(obi_req.req),   64'd1);
            check({tag, ".addr"},  64'(obi_req.addr),  64'(exp_addr));
            check({tag, ".be"},    64'(obi_req.be),    64'(exp_be));
            check({tag, ".we"},    64'(obi_req.we),    64'(wr));
            check({tag, ".wdata"}, 64'(obi_req.wdata), 64'(wdata));
            check({tag, ".rdy_lo"}, 64'(reg_rsp.ready), 64'd0);
            obi_resp.gnt = (i == gd);
            step();
        end
        obi_resp.gnt = 1'b0;
        for (int j = 0; j <= rd; j++) begin
            check({tag, ".req_lo"}, 64'(obi_req.req),   64'd0);
            check({tag, ".rdy_lo"}, 64'(reg_rsp.ready), 64'd0);
            obi_resp.rvalid = (j == rd);
            obi_resp.rdata  = (j == rd) ? bus_rd : $urandom();
            step();
        end
        obi_resp.rvalid = 1'b0;
        check({tag, ".ready"}, 64'(reg_rsp.ready), 64'd1);
        reg_req.valid = 1'b0;
    endtask

    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int gd, input int rd,
                       input logic [31:0] bus_rd, input string tag);
        drive_req(wr, addr, wdata, strb, 1'b1, {(wr ? 32'h0 : bus_rd), 1'b0});
        step();
        txn_body(wr, addr, wdata, strb, gd, rd, bus_rd, tag);
        step();
        check({tag, ".pulse"}, 64'(reg_rsp.ready), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req"},   64'(obi_req.req),   64'd0);
        check({tag, ".we"},    64'(obi_req.we),    64'd0);
        check({tag, ".be"},    64'(obi_req.be),    64'd0);
        check({tag, ".addr"},  64'(obi_req.addr),  64'd0);
        check({tag, ".wdata"}, 64'(obi_req.wdata), 64'd0);
        check({tag, ".ready"}, 64'(reg_rsp.ready), 64'd0);
        check({tag, ".rdata"}, 64'(reg_rsp.rdata), 64'd0);
        check({tag, ".error"}, 64'(reg_rsp.error), 64'd0);
    endtask

    initial begin
        logic        wr;
        int          idx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          ready_base;

        rst      = 1'b1;
        reg_req  = '0;
        obi_resp = '0;
        for (int i = 0; i < 4; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        step();

        txn(1'b0, 32'h2000_0006, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, "rd_zero_wait");
        txn(1'b1, 32'h1000_0010, 32'h1234_5678, 4'b0011, 3, 2, 32'hFFFF_FFFF, "wr_stall");

        // Timeout: grant in cycle 1, error ready in cycle 7, stale rvalid in cycle 11.
        drive_req(1'b0, 32'h2000_0200, 32'h0, 4'h0, 1'b1, {32'h0, 1'b1});
        step();
        check("tmo.req", 64'(obi_req.req), 64'd1);
        obi_resp.gnt = 1'b1;
        step();
        obi_resp.gnt = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            check("tmo.rdy_lo", 64'(reg_rsp.ready), 64'd0);
            step();
        end
        check("tmo.ready", 64'(reg_rsp.ready), 64'd1);
        reg_req.valid = 1'b0;
        step();
        drive_req(1'b0, 32'h2000_0300, 32'h0, 4'h0, 1'b1, {32'h1357_9BDF, 1'b0});
        for (int c = 8; c <= 11; c++) begin
            check("drain.req_lo", 64'(obi_req.req),   64'd0);
            check("drain.rdy_lo", 64'(reg_rsp.ready), 64'd0);
            obi_resp.rvalid = (c == 11);
            obi_resp.rdata  = 32'hBAD0_BAD0;
            step();
        end
        obi_resp.rvalid = 1'b0;
        check("drain.idle_req", 64'(obi_req.req),   64'd0);
        check("drain.idle_rdy", 64'(reg_rsp.ready), 64'd0);
        step();
        txn_body(1'b0, 32'h2000_0300, 32'h0, 4'h0, 0, 0, 32'h1357_9BDF, "after_drain");
        step();

        txn(1'b0, 32'h2000_0100, 32'h0, 4'h0, 0, TMO, 32'hCAFE_F00D, "simul_tmo");
        txn(1'b0, 32'h2000_0104, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D, "post_simul");

        // Reset while req is waiting for a grant.
        drive_req(1'b1, 32'h4000_000C, 32'h5555_AAAA, 4'hC, 1'b0, '0);
        step();
        check("rst_req.req", 64'(obi_req.req), 64'd1);
        rst = 1'b1;
        reg_req.valid = 1'b0;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_req");
        txn(1'b0, 32'h2000_0040, 32'h0, 4'h0, 1, 1, 32'h6666_1111, "rst_req_follow");

        // Reset while waiting for rvalid; the late rvalid afterwards is ignored.
        drive_req(1'b0, 32'h2000_0044, 32'h0, 4'h0, 1'b0, '0);
        step();
        obi_resp.gnt = 1'b1;
        step();
        obi_resp.gnt = 1'b0;
        check("rst_wait.req_lo", 64'(obi_req.req), 64'd0);
        rst = 1'b1;
        reg_req.valid = 1'b0;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_wait");
        obi_resp.rvalid = 1'b1;
        obi_resp.rdata  = 32'h7777_7777;
        step();
        obi_resp.rvalid = 1'b0;
        check("rst_wait.stale", 64'(reg_rsp.ready), 64'd0);
        txn(1'b0, 32'h2000_0048, 32'h0, 4'h0, 0, 2, 32'h2468_ACE0, "rst_wait_follow");

        ready_base = n_ready;
        for (int k = 0; k < 8; k++) begin
            wr    = 1'($urandom_range(0, 1));
            idx   = int'($urandom_range(0, 3));
            addr  = 32'h3000_0000 + 32'(idx * 4) + 32'($urandom_range(0, 3));
            wdata = $urandom();
            strb  = 4'($urandom_range(1, 15));
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
                end
                txn(1'b1, addr, wdata, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    32'hFFFF_FFFF, "rand_wr");
            end else begin
                txn(1'b0, addr, wdata, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    mem[idx], "rand_rd");
            end
        end
        check("rand.ready_count", 64'(n_ready - ready_base), 64'd8);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("total_ready", 64'(n_ready), 64'(n_pushed));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
